// File: rtl/seven_segment_reader.sv
// Receive side of a multiplexed active-low seven-segment bus: waits for each
// {an, seg} pattern to settle, then decodes it into the selected digit's nibble.
module seven_segment_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  err,
    output logic [2:0]            err_digit
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [DIGITS-1:0] s_an;
    logic [6:0]        s_seg;
    logic [DIGITS-1:0] seen;
    logic              capture;
    logic              one_hot;
    logic              same;
    logic [2:0]        idx;
    logic              legal;
    logic [3:0]        nib;
    int unsigned       zeros;

    // Count active (low) anodes and locate the selected digit.
    always_comb begin
        zeros = 0;
        idx   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!an[i]) begin
                zeros = zeros + 1;
                idx   = 3'(i);
            end
        end
        one_hot = (zeros == 1);
        same    = (an == s_an) && (seg == s_seg);
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (seg)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // Inputs are compared against the previous edge's sample, so the first
    // edge of a new pattern counts as 1 and capture lands on edge STABLE_CYCLES.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        if (!one_hot) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (state == IDLE || !same) begin
            state_next = COUNT;
            cnt_next   = CW'(1);
        end else if (state == COUNT) begin
            if (cnt == CW'(STABLE_CYCLES - 1)) begin
                capture    = 1'b1;
                state_next = HELD;
                cnt_next   = CW'(STABLE_CYCLES);
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            s_an  <= '1;
            s_seg <= '1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            s_an  <= an;
            s_seg <= seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
            seen        <= '0;
        end else begin
            frame_valid <= 1'b0;
            err         <= 1'b0;
            if (capture) begin
                if (legal) begin
                    digits[4*int'(idx) +: 4] <= nib;
                    digit_valid[idx]         <= 1'b1;
                    if (&(seen | ~an)) begin
                        frame_valid <= 1'b1;
                        seen        <= '0;
                    end else begin
                        seen <= seen | ~an;
                    end
                end else begin
                    digit_valid[idx] <= 1'b0;
                    seen[idx]        <= 1'b0;
                    err              <= 1'b1;
                    err_digit        <= idx;
                end
            end
        end
    end

endmodule
